seq_chunk_adder: RTL

//  Multi-cycle, parametrised add/subtract unit. Reuses one CHUNK-bit ripple adder across

---
 rtl/seq_chunk_adder_pkg.sv | 18 +
 rtl/chunk_ripple_adder.sv | 30 +++
 rtl/seq_chunk_adder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and defaults for the chunked sequential adder.
// Also holds the one-bit full-adder cell that the chunk adder chains together.
package seq_chunk_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational W-bit ripple-carry adder built from a chain of full-adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module chunk_ripple_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int unsigned W = DEFAULT_CHUNK
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < W; i++) begin
            {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
        end
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple adder reused over WIDTH/CHUNK cycles,
// LSB chunk first, with start/busy/done handshake and registered sum/carry/ovf.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = $clog2(NCHUNK) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("seq_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             cr_q, cr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;

    chunk_ripple_adder #(.W(CHUNK)) u_rca (
        .a    (opa_q[CHUNK-1:0]),
        .b    (opb_q[CHUNK-1:0]),
        .cin  (cr_q),
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cr_d    = cr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + ~cin, so cin behaves as a borrow-in.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    cr_d    = sub ^ cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                opa_d = opa_q >> CHUNK;
                opb_d = opb_q >> CHUNK;
                res_d = res_q >> CHUNK;
                res_d[WIDTH-1 -: CHUNK] = chunk_sum;
                cr_d  = chunk_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    sum_d   = res_d;
                    carry_d = chunk_cout;
                    ovf_d   = chunk_cout ^ chunk_cmsb;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cr_q    <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cr_q    <= cr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule
